// File: rtl/uc_seq_if.sv
// Instruction/control bundle between program memory/datapath (master) and the
// uc_seq control unit (slave).
interface uc_seq_if;
  logic [5:0] opcode;
  logic [9:0] operand;
  logic       z;
  logic       s_inc, s_inm, we3, entI, SalR, SalI, s_jr, c_jr, s_rel;
  logic [2:0] op;
  logic       halted, busy;

  modport master (
    output opcode, operand, z,
    input  s_inc, s_inm, we3, entI, SalR, SalI, s_jr, c_jr, s_rel, op, halted, busy
  );
  modport slave (
    input  opcode, operand, z,
    output s_inc, s_inm, we3, entI, SalR, SalI, s_jr, c_jr, s_rel, op, halted, busy
  );
endinterface

// File: rtl/uc_seq.sv
// Control/sequencing unit: combinational opcode decode, zero flag, RUN/HALT FSM.
// Define UC_TIMER_EN to build the prescaled busy-wait timer (SETT/WAITT/busy).
module uc_seq #(
  parameter int PRESCALE = 1000,
  parameter int PW       = 16
) (
  input logic     clk,
  input logic     reset,
  uc_seq_if.slave bus
);
  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t     r_state;
  logic       r_zf;
  logic [5:0] w_opc;
  logic       w_tmr_nz;

  assign w_opc = bus.opcode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_zf    <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_opc[5]) r_zf <= bus.z;
      if (w_opc == 6'b010110) r_state <= S_HALT;
    end
  end

`ifdef UC_TIMER_EN
  logic [PW-1:0] r_pre;
  logic [9:0]    r_timer;
  logic          w_tick, w_sett;

  assign w_tick   = (r_pre == PW'(PRESCALE - 1));
  assign w_sett   = (r_state == S_RUN) && (w_opc[5:2] == 4'b0100);
  assign w_tmr_nz = (r_timer != 10'd0);

  // A SETT load overrides any decrement from a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre   <= '0;
      r_timer <= '0;
    end else if (w_sett) begin
      r_pre   <= '0;
      r_timer <= bus.operand;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick && w_tmr_nz) r_timer <= r_timer - 10'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^bus.operand ^ (PRESCALE > PW);
  assign w_tmr_nz = 1'b0;
`endif

  always_comb begin
    bus.s_inc  = 1'b0;
    bus.s_inm  = 1'b0;
    bus.we3    = 1'b0;
    bus.entI   = 1'b0;
    bus.SalR   = 1'b0;
    bus.SalI   = 1'b0;
    bus.s_jr   = 1'b0;
    bus.c_jr   = 1'b0;
    bus.s_rel  = 1'b0;
    bus.op     = w_opc[4:2];
    bus.halted = 1'b0;
    bus.busy   = 1'b0;
    if (reset) begin
      bus.s_inc = 1'b1;
      bus.op    = 3'd0;
    end else if (r_state == S_HALT) begin
      // Re-fetch the HALT word at PC+0 forever.
      bus.s_inc  = 1'b1;
      bus.s_rel  = 1'b1;
      bus.halted = 1'b1;
    end else begin
      casez (w_opc)
        6'b1?????: begin bus.we3 = 1'b1; bus.s_inc = 1'b1; end
        6'b0000??: begin bus.we3 = 1'b1; bus.s_inm = 1'b1; bus.entI = 1'b1; bus.s_inc = 1'b1; end
        6'b0001??: begin bus.we3 = 1'b1; bus.s_inm = 1'b1; bus.s_inc = 1'b1; end
        6'b001000: bus.s_jr = 1'b1;
        6'b001001: if (r_zf) bus.s_jr = 1'b1; else bus.s_inc = 1'b1;
        6'b001010: if (!r_zf) bus.s_jr = 1'b1; else bus.s_inc = 1'b1;
        6'b001011: begin bus.s_inc = 1'b1; bus.s_rel = 1'b1; end
        6'b001100: begin bus.c_jr = 1'b1; bus.s_jr = 1'b1; end
        6'b001101: ;
        6'b001110: begin bus.SalR = 1'b1; bus.s_inc = 1'b1; end
        6'b001111: begin bus.SalI = 1'b1; bus.s_inc = 1'b1; end
        6'b010100: begin
          bus.s_inc = 1'b1;
          if (w_tmr_nz) begin bus.s_rel = 1'b1; bus.busy = 1'b1; end
        end
        6'b010110: ;
        default:   bus.s_inc = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_uc_seq.sv
// Directed + randomized bench for uc_seq against a behavioural reference model.
module tb_uc_seq;
  localparam int P = 4;
`ifdef UC_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  uc_seq_if bus();

  uc_seq #(.PRESCALE(P), .PW(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit m_zf, m_halt;
  int m_tmr, m_pre;
  int cur_opc, cur_opr;
  bit cur_z;

  logic [13:0] w_obs;
  assign w_obs = {bus.s_inc, bus.s_inm, bus.we3, bus.entI, bus.SalR, bus.SalI,
                  bus.s_jr, bus.c_jr, bus.s_rel, bus.op, bus.halted, bus.busy};

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [13:0] model(input int opc, input bit rst);
    bit inc = 0, inm = 0, we = 0, ei = 0, sr = 0, si = 0, jr = 0, cj = 0, rel = 0, h = 0, b = 0;
    logic [2:0] opv;
    opv = 3'((opc >> 2) & 7);
    if (rst) begin inc = 1; opv = 3'd0; end
    else if (m_halt) begin inc = 1; rel = 1; h = 1; end
    else if (opc >= 32) begin we = 1; inc = 1; end
    else if (opc < 4) begin we = 1; inm = 1; ei = 1; inc = 1; end
    else if (opc < 8) begin we = 1; inm = 1; inc = 1; end
    else if (opc == 8) jr = 1;
    else if (opc == 9) begin if (m_zf) jr = 1; else inc = 1; end
    else if (opc == 10) begin if (!m_zf) jr = 1; else inc = 1; end
    else if (opc == 11) begin inc = 1; rel = 1; end
    else if (opc == 12) begin cj = 1; jr = 1; end
    else if (opc == 13) ;
    else if (opc == 14) begin sr = 1; inc = 1; end
    else if (opc == 15) begin si = 1; inc = 1; end
    else if (opc == 20 && TEN && m_tmr != 0) begin inc = 1; rel = 1; b = 1; end
    else if (opc == 22) ;
    else inc = 1;
    return {inc, inm, we, ei, sr, si, jr, cj, rel, opv, h, b};
  endfunction

  task automatic model_clear();
    m_zf = 0; m_halt = 0; m_tmr = 0; m_pre = 0;
  endtask

  task automatic model_edge(input int opc, input int opr, input bit zin);
    bit sett;
    sett = !m_halt && TEN && opc >= 16 && opc < 20;
    if (!m_halt && opc >= 32) m_zf = zin;
    if (TEN) begin
      if (sett) begin m_tmr = opr; m_pre = 0; end
      else if (m_pre == P - 1) begin m_pre = 0; if (m_tmr > 0) m_tmr--; end
      else m_pre++;
    end
    if (!m_halt && opc == 22) m_halt = 1;
  endtask

  task automatic drive(input int opc, input int opr, input bit zin, input string tag);
    bus.opcode = opc[5:0]; bus.operand = opr[9:0]; bus.z = zin;
    cur_opc = opc; cur_opr = opr; cur_z = zin;
    @(negedge clk);
    chk(tag, w_obs, model(opc, reset));
  endtask

  task automatic adv();
    @(posedge clk);
    if (reset) model_clear();
    else model_edge(cur_opc, cur_opr, cur_z);
    #1;
  endtask

  initial begin
    int opc;
    reset = 1'b1;
    model_clear();
    drive(32, 0, 1, "reset_out");
    adv();
    reset = 1'b0;

    drive(32, 0, 1, "alu_z1"); adv();
    drive(9, 0, 0, "jz_taken");
    chk("jz_jr", 14'(bus.s_jr), 14'd1);
    chk("jz_inc", 14'(bus.s_inc), 14'd0);
    adv();
    drive(32, 0, 0, "alu_z0"); adv();
    drive(10, 0, 1, "jnz_taken");
    chk("jnz_jr", 14'(bus.s_jr), 14'd1);
    adv();
    drive(33, 0, 1, "alu_z1b"); adv();
    drive(0, 5, 0, "loadi"); adv();
    drive(9, 0, 0, "jz_after_loadi");
    chk("jz_after_loadi_jr", 14'(bus.s_jr), 14'd1);
    adv();
    drive(12, 0, 0, "call");
    chk("call_cjr_sjr", 14'({bus.c_jr, bus.s_jr}), 14'd3);
    adv();
    drive(13, 0, 0, "ret");
    chk("ret_ctrl_zero", 14'(w_obs[13:5]), 14'd0);
    adv();

    if (TEN) begin
      drive(16, 3, 0, "sett3"); adv();
      for (int i = 0; i < 12; i++) begin
        drive(20, 0, 0, "waitt_spin");
        chk("waitt_busy", 14'(bus.busy), 14'd1);
        adv();
      end
      drive(20, 0, 0, "waitt_exit");
      chk("waitt_exit_bits", 14'({bus.busy, bus.s_rel, bus.s_inc}), 14'b001);
      adv();
    end else begin
      drive(16, 5, 0, "sett_nop");
      chk("sett_nop_bits", 14'({bus.busy, bus.s_rel, bus.s_inc}), 14'b001);
      adv();
      drive(20, 0, 0, "waitt_nop");
      chk("waitt_nop_bits", 14'({bus.busy, bus.s_rel, bus.s_inc}), 14'b001);
      adv();
    end

    drive(22, 0, 0, "halt_op"); adv();
    for (int i = 0; i < 100; i++) begin
      drive(32 + (i % 32), i % 8, i[0], "halt_hold");
      chk("halt_flags", 14'({bus.halted, bus.s_rel, bus.we3, bus.SalR, bus.SalI}), 14'b11000);
      adv();
    end
    #2 reset = 1'b1;
    #1 chk("halt_async_clear", 14'(bus.halted), 14'd0);
    model_clear();
    drive(22, 0, 0, "reset_in_halt");
    adv();
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        model_clear();
        drive(int'($urandom_range(0, 63)), 0, 0, "rnd_reset");
        adv();
        reset = 1'b0;
      end else begin
        opc = int'($urandom_range(0, 63));
        if (opc == 22 && $urandom_range(0, 3) != 0) opc = 20;
        drive(opc, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), "rnd");
        adv();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
